// File: rtl/multi_clken_gen_pkg.sv
// Shared definitions for the multi-channel NCO clock-enable generator:
// width helpers and standard increments for a 50 MHz master clock.
package multi_clken_gen_pkg;

    // Ceiling log2, usable in constant expressions for port and counter widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Lock counter must be able to hold the value LOCK_CNT itself.
    function automatic int lock_width(input int lock_cnt);
        return clog2(lock_cnt + 1);
    endfunction

    // Increments for a 50 MHz master clock with a 24-bit accumulator.
    localparam logic [23:0] INC_50M_TO_28M636 = 24'd9608667;
    localparam logic [23:0] INC_50M_TO_32M    = 24'd10737418;
    localparam logic [23:0] INC_50M_TO_24M    = 24'd8053064;

endpackage

// File: rtl/multi_clken_gen_nco.sv
// One phase-accumulator channel: increment register, accumulator, registered
// carry as the enable pulse, and a saturating lock counter driving lock.
module nco_clken_ch
    import multi_clken_gen_pkg::*;
#(
    parameter int                 ACC_W     = 24,
    parameter int                 LOCK_CNT  = 16,
    parameter logic [ACC_W-1:0]   INC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             we,
    input  logic [ACC_W-1:0] winc,
    output logic             clken,
    output logic             lock
);

    localparam int LOCK_W = lock_width(LOCK_CNT);

    logic [ACC_W-1:0]  inc;
    logic [ACC_W-1:0]  acc;
    logic [LOCK_W-1:0] lock_cnt;
    logic [ACC_W:0]    sum;

    // One extra bit on the sum exposes the wrap of the accumulator as the carry.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, inc};
    end

    // Priority: reset, own write, cascade hold, idle on zero increment, accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc      <= INC_RESET;
            acc      <= '0;
            lock_cnt <= '0;
            clken    <= 1'b0;
            lock     <= 1'b0;
        end else if (we) begin
            inc      <= winc;
            acc      <= '0;
            lock_cnt <= '0;
            clken    <= 1'b0;
            lock     <= 1'b0;
        end else if (hold) begin
            acc      <= '0;
            lock_cnt <= '0;
            clken    <= 1'b0;
            lock     <= 1'b0;
        end else if (inc != '0) begin
            acc   <= sum[ACC_W-1:0];
            clken <= sum[ACC_W];
            if (clken && (lock_cnt != LOCK_W'(LOCK_CNT))) begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
                if (lock_cnt == LOCK_W'(LOCK_CNT - 1)) begin
                    lock <= 1'b1;
                end
            end
        end else begin
            clken <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_clken_gen.sv
// Multi-channel clock-enable generator: NUM_CH NCO channels on one master
// clock, runtime-writable increments, per-channel and combined lock, and an
// optional cascade that holds channels 1..N-1 until channel 0 has locked.
module multi_clken_gen
    import multi_clken_gen_pkg::*;
#(
    parameter int                        NUM_CH   = 4,
    parameter int                        ACC_W    = 24,
    parameter int                        LOCK_CNT = 16,
    parameter logic [NUM_CH*ACC_W-1:0]   INC_INIT = '0,
    parameter int                        CASCADE  = 1,
    parameter int                        WSEL_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              I_CLK,
    input  logic              I_RESET,
    input  logic              I_WE,
    input  logic [WSEL_W-1:0] I_WSEL,
    input  logic [ACC_W-1:0]  I_WINC,
    output logic [NUM_CH-1:0] O_CLKEN,
    output logic [NUM_CH-1:0] O_LOCK,
    output logic              O_ALL_LOCK
);

    logic [NUM_CH-1:0] ch_we;
    logic [NUM_CH-1:0] ch_hold;

    // Out-of-range selects match no channel, so such writes change nothing.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_we[k] = I_WE && (I_WSEL == WSEL_W'(k));
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            // Downstream channels are held while channel 0 is unlocked or being rewritten.
            if ((CASCADE != 0) && (k >= 1)) begin : g_hold
                assign ch_hold[k] = !O_LOCK[0] || ch_we[0];
            end else begin : g_free
                assign ch_hold[k] = 1'b0;
            end

            nco_clken_ch #(
                .ACC_W     (ACC_W),
                .LOCK_CNT  (LOCK_CNT),
                .INC_RESET (INC_INIT[k*ACC_W +: ACC_W])
            ) u_ch (
                .clk   (I_CLK),
                .reset (I_RESET),
                .hold  (ch_hold[k]),
                .we    (ch_we[k]),
                .winc  (I_WINC),
                .clken (O_CLKEN[k]),
                .lock  (O_LOCK[k])
            );
        end
    endgenerate

    // Combined lock follows the last channel lock by one cycle.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            O_ALL_LOCK <= 1'b0;
        end else begin
            O_ALL_LOCK <= &O_LOCK;
        end
    end

endmodule
